// File: rtl/brick_hit_pkg.sv
// Shared brick-grid geometry and field types for the brick hit responder.
// Defaults describe a 16x4 grid of 4x2-pixel bricks with a 16-cycle draw hold-off.
package brick_hit_pkg;

  localparam int DEF_GRIDX       = 16;
  localparam int DEF_GRIDY       = 4;
  localparam int DEF_BRICKX_LOG2 = 2;
  localparam int DEF_BRICKY_LOG2 = 1;
  localparam int DEF_BRICKNUM    = DEF_GRIDX * DEF_GRIDY;
  localparam int DEF_DRAW_DELAY  = 16;

  localparam int COORD_W  = 10;
  localparam int ADDR_W   = 10;
  localparam int HEALTH_W = 2;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [HEALTH_W-1:0] health_t;

endpackage

// File: rtl/brick_hit_if.sv
// Request, brick RAM and draw-path signals of the brick hit responder.
// master = ball control plus RAM/VGA environment, slave = brick_hit.
interface brick_hit_if;
  import brick_hit_pkg::*;

  logic    req;
  coord_t  ball_x;
  coord_t  ball_y;
  logic    busy;
  addr_t   rd_addr;
  logic    rd_en;
  health_t rd_data;
  logic    wr_en;
  addr_t   wr_addr;
  health_t wr_data;
  logic    draw;
  coord_t  x_out;
  coord_t  y_out;
  health_t health_out;
  logic    done;
  logic    hit;
  logic    destroyed;

  modport master (
    output req, ball_x, ball_y, rd_data,
    input  busy, rd_addr, rd_en, wr_en, wr_addr, wr_data,
           draw, x_out, y_out, health_out, done, hit, destroyed
  );

  modport slave (
    input  req, ball_x, ball_y, rd_data,
    output busy, rd_addr, rd_en, wr_en, wr_addr, wr_data,
           draw, x_out, y_out, health_out, done, hit, destroyed
  );

endinterface

// File: rtl/brick_locate.sv
// Combinational map from a ball pixel position to its brick address and the
// brick's top-left pixel, with an in-grid flag.
module brick_locate
  import brick_hit_pkg::*;
#(
  parameter int GRIDX       = DEF_GRIDX,
  parameter int GRIDY       = DEF_GRIDY,
  parameter int BRICKX_LOG2 = DEF_BRICKX_LOG2,
  parameter int BRICKY_LOG2 = DEF_BRICKY_LOG2
) (
  input  coord_t ball_x_i,
  input  coord_t ball_y_i,
  output addr_t  addr_o,
  output logic   in_grid_o,
  output coord_t x_o,
  output coord_t y_o
);

  coord_t col;
  coord_t row;

  assign col = ball_x_i >> BRICKX_LOG2;
  assign row = ball_y_i >> BRICKY_LOG2;

  // Full-width compare so large coordinates never alias back into the grid
  assign in_grid_o = (col < COORD_W'(GRIDX)) && (row < COORD_W'(GRIDY));
  assign addr_o    = ADDR_W'(row * COORD_W'(GRIDX) + col);
  assign x_o       = col << BRICKX_LOG2;
  assign y_o       = row << BRICKY_LOG2;

endmodule

// File: rtl/brick_hit.sv
// Read-modify-write responder on brick health RAM: looks up the brick under the
// ball, decrements its health, writes it back, requests a redraw and reports status.
module brick_hit
  import brick_hit_pkg::*;
#(
  parameter int GRIDX       = DEF_GRIDX,
  parameter int GRIDY       = DEF_GRIDY,
  parameter int BRICKX_LOG2 = DEF_BRICKX_LOG2,
  parameter int BRICKY_LOG2 = DEF_BRICKY_LOG2,
  parameter int DRAW_DELAY  = DEF_DRAW_DELAY
) (
  input  logic        clk,
  input  logic        resetn,
  brick_hit_if.slave  bus
);

  localparam int CNT_W = (DRAW_DELAY > 1) ? $clog2(DRAW_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_CHECK    = 3'd2,
    S_WRITE    = 3'd3,
    S_DRAW     = 3'd4,
    S_DRAWWAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  addr_t            addr_q, addr_d;
  coord_t           x_q, x_d;
  coord_t           y_q, y_d;
  health_t          newh_q, newh_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  addr_t  loc_addr;
  logic   loc_in_grid;
  coord_t loc_x;
  coord_t loc_y;

  brick_locate #(
    .GRIDX       (GRIDX),
    .GRIDY       (GRIDY),
    .BRICKX_LOG2 (BRICKX_LOG2),
    .BRICKY_LOG2 (BRICKY_LOG2)
  ) u_locate (
    .ball_x_i  (bus.ball_x),
    .ball_y_i  (bus.ball_y),
    .addr_o    (loc_addr),
    .in_grid_o (loc_in_grid),
    .x_o       (loc_x),
    .y_o       (loc_y)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      newh_q  <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      newh_q  <= newh_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; req outside IDLE is simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = loc_in_grid ? S_READ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.rd_data == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DRAW;
      S_DRAW:  state_d = S_DRAWWAIT;
      S_DRAWWAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAWWAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch on accept, capture health in CHECK, count in DRAWWAIT
  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    newh_d = newh_q;
    hit_d  = hit_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d = loc_addr;
          x_d    = loc_x;
          y_d    = loc_y;
          newh_d = '0;
          hit_d  = 1'b0;
        end else begin
          addr_d = addr_q;
        end
      end
      S_CHECK: begin
        if (bus.rd_data != '0) begin
          hit_d  = 1'b1;
          newh_d = bus.rd_data - 2'd1;
        end else begin
          hit_d  = 1'b0;
          newh_d = '0;
        end
      end
      S_DRAW:     cnt_d = '0;
      S_DRAWWAIT: cnt_d = cnt_q + 1'b1;
      default:    cnt_d = cnt_q;
    endcase
  end

  // Moore outputs decoded from registered state and latched fields
  always_comb begin
    bus.busy       = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.draw       = 1'b0;
    bus.x_out      = '0;
    bus.y_out      = '0;
    bus.health_out = '0;
    bus.done       = 1'b0;
    bus.hit        = 1'b0;
    bus.destroyed  = 1'b0;
    if (state_q != S_IDLE) begin
      bus.busy    = 1'b1;
      bus.rd_addr = addr_q;
      bus.wr_addr = addr_q;
      bus.x_out   = x_q;
      bus.y_out   = y_q;
    end else begin
      bus.busy    = 1'b0;
    end
    case (state_q)
      S_READ:  bus.rd_en = 1'b1;
      S_WRITE: begin
        bus.wr_en   = 1'b1;
        bus.wr_data = newh_q;
      end
      S_DRAW: begin
        bus.draw       = 1'b1;
        bus.health_out = newh_q;
      end
      S_DRAWWAIT: bus.health_out = newh_q;
      S_DONE: begin
        bus.health_out = newh_q;
        bus.done       = 1'b1;
        bus.hit        = hit_q;
        bus.destroyed  = hit_q & (newh_q == '0);
      end
      default: bus.done = 1'b0;
    endcase
  end

endmodule
